apb4_plic_claimer: RTL

// - Hart-side APB4 initiator for the PLIC claim/complete protocol.
// - Sits between the PLIC's ext_irq_o line and a local interrupt consumer (core or DMA sequencer).
// - Sequence: on ext_irq, reads CLAIMCOMP (claim), hands the ID to the consumer, waits for the

---
 rtl/plic_pkg.sv | 28 ++
 rtl/apb4_plic_claimer_if.sv | 28 ++
 rtl/apb4_mst_xfer.sv | 75 +++++++
 rtl/apb4_plic_claimer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | plic_pkg: shared constants and state types for the PLIC claimer. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package plic_pkg;

  localparam logic [31:0] c_claimcomp_off = 32'h24;
  localparam int unsigned c_id_width_def  = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_SETUP  = 3'd1,
    ST_RD_ACCESS = 3'd2,
    ST_DISPATCH  = 3'd3,
    ST_WAIT_CMP  = 3'd4,
    ST_WR_SETUP  = 3'd5,
    ST_WR_ACCESS = 3'd6
  } claim_state_t;

  typedef enum logic [1:0] {
    XF_IDLE   = 2'd0,
    XF_SETUP  = 2'd1,
    XF_ACCESS = 2'd2
  } xfer_state_t;

endpackage
`default_nettype wire

// File: rtl/apb4_plic_claimer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb4_plic_claimer_if: APB4 bus bundle with master/slave views.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface apb4_plic_claimer_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb4_mst_xfer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb4_mst_xfer: single APB4 SETUP/ACCESS transfer engine.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module apb4_mst_xfer
  import plic_pkg::*;
(
  input  wire logic        pclk,
  input  wire logic        presetn,
  input  wire logic        i_req,
  input  wire logic [31:0] i_addr,
  input  wire logic        i_wr,
  input  wire logic [31:0] i_wdata,
  output logic             o_done,
  output logic [31:0]      o_rdata,
  output logic             o_err,
  apb4_plic_claimer_if.master apb
);

  xfer_state_t r_state;
  xfer_state_t w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_wr;
  logic [3:0]  r_strb;

  // Request is sampled only when idle; the command stays frozen until the next request.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= XF_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_strb  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == XF_IDLE && i_req) begin
        r_addr  <= i_addr;
        r_wdata <= i_wr ? i_wdata : '0;
        r_wr    <= i_wr;
        r_strb  <= i_wr ? 4'hF : 4'h0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    o_done = 1'b0;
    case (r_state)
      XF_IDLE:   if (i_req) w_next = XF_SETUP;
      XF_SETUP:  w_next = XF_ACCESS;
      XF_ACCESS: begin
        if (apb.pready) begin
          o_done = 1'b1;
          w_next = XF_IDLE;
        end
      end
      default:   w_next = XF_IDLE;
    endcase
  end

  assign o_rdata     = apb.prdata;
  assign o_err       = o_done & apb.pslverr;

  assign apb.psel    = (r_state != XF_IDLE);
  assign apb.penable = (r_state == XF_ACCESS);
  assign apb.pwrite  = r_wr;
  assign apb.paddr   = r_addr;
  assign apb.pwdata  = r_wdata;
  assign apb.pstrb   = r_strb;
  assign apb.pprot   = 3'b000;

endmodule
`default_nettype wire

// File: rtl/apb4_plic_claimer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | apb4_plic_claimer: hart-side PLIC claim/complete APB4 initiator. |
// | Optional completion timeout: PLIC_CLAIMER_TIMEOUT_EN. Rev 1.0    |
// +------------------------------------------------------------------+
module apb4_plic_claimer
  import plic_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned ID_WIDTH  = c_id_width_def,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned TO_CYCLES = 1024
) (
  input  wire logic                 pclk,
  input  wire logic                 presetn,
  input  wire logic                 en_i,
  input  wire logic                 ext_irq_i,
  apb4_plic_claimer_if.master       apb,
  output logic                      irq_valid_o,
  output logic [ID_WIDTH-1:0]       irq_id_o,
  input  wire logic                 irq_ready_i,
  input  wire logic                 cmp_valid_i,
  output logic                      cmp_ready_o,
  output logic                      busy_o,
  output logic                      err_o,
  output logic [CNT_WIDTH-1:0]      claim_cnt_o
);

  claim_state_t          r_state;
  claim_state_t          w_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_err;

  logic                  w_req;
  logic                  w_wr;
  logic                  w_done;
  logic                  w_xerr;
  logic                  w_timeout;
  logic [31:0]           w_rdata;
  logic [ID_WIDTH-1:0]   w_rd_id;
  logic [31-ID_WIDTH:0]  w_unused_rdata;

  assign w_rd_id        = w_rdata[ID_WIDTH-1:0];
  assign w_unused_rdata = w_rdata[31:ID_WIDTH];

  apb4_mst_xfer u_xfer (
    .pclk    (pclk),
    .presetn (presetn),
    .i_req   (w_req),
    .i_addr  (BASE_ADDR + c_claimcomp_off),
    .i_wr    (w_wr),
    .i_wdata (32'(r_id)),
    .o_done  (w_done),
    .o_rdata (w_rdata),
    .o_err   (w_xerr),
    .apb     (apb)
  );

`ifdef PLIC_CLAIMER_TIMEOUT_EN
  localparam int unsigned c_to_w = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  logic [c_to_w-1:0] r_to_cnt;

  // Restarts from zero on every state change, so each waiting state gets its own budget.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_to_cnt <= '0;
    end else if (r_state != w_next) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_DISPATCH || r_state == ST_WAIT_CMP) begin
      r_to_cnt <= r_to_cnt + c_to_w'(1);
    end
  end

  assign w_timeout = (r_state == ST_DISPATCH || r_state == ST_WAIT_CMP) &&
                     (r_to_cnt == c_to_w'(TO_CYCLES - 1));
`else
  localparam int unsigned c_unused_to = TO_CYCLES;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((w_done && w_xerr) || w_timeout) begin
        r_err <= 1'b1;
      end
      if (r_state == ST_RD_ACCESS && w_done && !w_xerr && w_rd_id != '0) begin
        r_id  <= w_rd_id;
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_req       = 1'b0;
    w_wr        = 1'b0;
    irq_valid_o = 1'b0;
    cmp_ready_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en_i && ext_irq_i) begin
          w_req  = 1'b1;
          w_next = ST_RD_SETUP;
        end
      end
      ST_RD_SETUP:  w_next = ST_RD_ACCESS;
      ST_RD_ACCESS: begin
        if (w_done) begin
          w_next = (w_xerr || w_rd_id == '0) ? ST_IDLE : ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        // A timeout withdraws the offer in the same cycle so no late handshake slips through.
        if (w_timeout) begin
          w_req  = 1'b1;
          w_wr   = 1'b1;
          w_next = ST_WR_SETUP;
        end else begin
          irq_valid_o = 1'b1;
          if (irq_ready_i) w_next = ST_WAIT_CMP;
        end
      end
      ST_WAIT_CMP: begin
        cmp_ready_o = 1'b1;
        if (cmp_valid_i || w_timeout) begin
          w_req  = 1'b1;
          w_wr   = 1'b1;
          w_next = ST_WR_SETUP;
        end
      end
      ST_WR_SETUP:  w_next = ST_WR_ACCESS;
      ST_WR_ACCESS: if (w_done) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  assign irq_id_o    = (r_state == ST_DISPATCH) ? r_id : '0;
  assign busy_o      = (r_state != ST_IDLE);
  assign err_o       = r_err;
  assign claim_cnt_o = r_cnt;

endmodule
`default_nettype wire
